pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game sequencer for Pong: owns ball position/velocity, paddle/wall collision, scoring,
//  serve timing and win detection. Drives ball_x/ball_y to the VGA renderer, reads paddle
//  positions from paddle control. All motion advances on an internal frame tick, ~60 Hz at 50 MHz.
// PARAMETERS
//  TICK_DIV     833333  CLOCK_50 cycles per frame tick (>=2)
//  H_ACTIVE     640     playfield width, px
//  V_ACTIVE     480     playfield height, px
//  BALL_SIZE    8       ball edge length, px
//  PADDLE_H     64      paddle height, px
//  PADDLE_W     8       paddle width, px
//  PADDLE_L_X   16      left paddle left edge x
//  PADDLE_R_X   616     right paddle left edge x
//  BALL_SPEED   2       |dx| = |dy| px per tick (1..7)
//  SERVE_TICKS  60      ticks ball is held at centre before launch
//  WIN_SCORE    7       points to win (1..15)
// PORTS
//  CLOCK_50    in   1   system clock, 50 MHz
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   start/restart request, active-high level, async (2-FF synced inside)
//  paddleL_y   in   10  left paddle top y
//  paddleR_y   in   10  right paddle top y
//  ball_x      out  10  ball left edge x
//  ball_y      out  10  ball top edge y
//  score_l     out  4   left score
//  score_r     out  4   right score
//  game_state  out  3   0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER, 5 PAUSE
//  frame_tick  out  1   one-cycle pulse per frame tick
// BEHAVIOUR
//  Reset: state IDLE; ball at centre CX=(H_ACTIVE-BALL_SIZE)/2, CY=(V_ACTIVE-BALL_SIZE)/2;
//   scores 0; frame_tick 0; tick counter 0; dx=+BALL_SPEED, dy=+BALL_SPEED.
//  Tick counter runs 0..TICK_DIV-1 in every state. frame_tick=1 for the cycle the counter
//   equals TICK_DIV-1. All ball/serve updates occur only on frame_tick cycles.
//  start_pulse = rising edge of synced start (3-cycle latency from pin); acts on any cycle.
//  IDLE  -start_pulse-> SERVE: scores cleared, ball centred, serve counter = SERVE_TICKS.
//  SERVE: ball held at centre; counter decrements per tick; at 0 -> PLAY (next tick moves ball).
//  PLAY, per tick: nx=ball_x+dx, ny=ball_y+dy evaluated in 11-bit signed arithmetic.
//   Y: ny<=0 -> y=0, dy=+S; ny>=V_ACTIVE-BALL_SIZE -> y=V_ACTIVE-BALL_SIZE, dy=-S; else y=ny.
//   Left hit: dx<0, nx<=PADDLE_L_X+PADDLE_W, ball_x>=PADDLE_L_X+PADDLE_W (no pass-through),
//    ball_y+BALL_SIZE>paddleL_y, ball_y<paddleL_y+PADDLE_H -> x=PADDLE_L_X+PADDLE_W, dx=+S.
//   Right hit: dx>0, nx+BALL_SIZE>=PADDLE_R_X, ball_x+BALL_SIZE<=PADDLE_R_X, y overlap with
//    paddleR_y -> x=PADDLE_R_X-BALL_SIZE, dx=-S.
//   Miss: nx<=0 -> score_r+1; nx>=H_ACTIVE-BALL_SIZE -> score_l+1; x clamped to edge; -> POINT.
//   Wall and paddle/miss on same tick: both applied. Overlap test uses pre-move ball_y.
//  POINT (one tick): if scorer reached WIN_SCORE -> OVER, else ball centred, dx toward the
//   player who lost the point, dy negated from last serve, counter=SERVE_TICKS -> SERVE.
//  OVER: ball frozen, scores held; start_pulse -> SERVE with full restart as from IDLE.
//  start_pulse in SERVE/PLAY/POINT: ignored. Scores never exceed WIN_SCORE.
//  Paddle inputs sampled only on tick cycles; mid-game reset returns everything to reset values.
// CONFIGURATION
//  PONG_PAUSE_EN defined: adds input `pause` (1 bit, async, 2-FF synced). Rising edge in PLAY
//   -> PAUSE (ball, velocity, scores frozen; tick counter keeps running); rising edge in PAUSE
//   -> PLAY on next tick. Ignored in other states. start_pulse in PAUSE -> IDLE-style restart.
//  Undefined: no pause port; state 5 unreachable; PLAY behaviour unchanged.
// TESTING (bench uses TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=2, BALL_SPEED=2)
//  Reset -> ball (316,236), scores 0/0, state 0; frame_tick every 4th cycle.
//  start high -> state 1 after sync; after 2 ticks state 2; next tick ball (318,238).
//  Ball forced to y=1, dy=-2 -> y=0, dy=+2 on next tick; y=471, dy=+2 -> y=472, dy=-2.
//  paddleL_y=200, ball (26,220) dx=-2 -> x=24, dx=+2, no score change.
//  Left paddle at 0, ball at x=2 dx=-2, y=300 -> score_r=1, POINT, then SERVE with dx=-2.
//  Two right points -> state 4, score_r=2 frozen; start pulse -> scores 0/0, state 1.
//  PONG_PAUSE_EN: pause edge in PLAY -> state 5, ball fixed 10 ticks; second edge -> resumes.

Source files
------------

// File: rtl/pong_game_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pong_game_if                                                   |
// | Purpose : Bundle between the Pong game sequencer, paddle control and the |
// |           VGA renderer.                                                  |
// | Signals : paddleL_y/paddleR_y (10) paddle top y, into the sequencer      |
// |           ball_x/ball_y (10)       ball top-left corner, to renderer     |
// |           score_l/score_r (4)      current scores                        |
// |           game_state (3)           0 IDLE,1 SERVE,2 PLAY,3 POINT,4 OVER, |
// |                                    5 PAUSE                               |
// |           frame_tick (1)           one-cycle pulse per frame             |
// | Modports: master = game sequencer, slave = renderer / paddle side        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface pong_game_if;
   logic [9:0] paddleL_y;
   logic [9:0] paddleR_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic [2:0] game_state;
   logic       frame_tick;

   modport master (
      input  paddleL_y, paddleR_y,
      output ball_x, ball_y, score_l, score_r, game_state, frame_tick
   );

   modport slave (
      output paddleL_y, paddleR_y,
      input  ball_x, ball_y, score_l, score_r, game_state, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pong_game_ctrl                                                 |
// | Purpose : Pong game sequencer. Owns ball position and velocity, wall and |
// |           paddle collision, scoring, serve timing and win detection.     |
// |           All motion advances on an internal frame tick.                 |
// | Ports   : CLOCK_50  in   system clock                                    |
// |           rst_n     in   asynchronous active-low reset                   |
// |           i_start   in   start/restart level, asynchronous (synced here) |
// |           i_pause   in   pause toggle level, asynchronous (option only)  |
// |           io_game   master side of pong_game_if (paddles in, ball,      |
// |                     scores, state and frame tick out)                    |
// | Option  : define PONG_PAUSE_EN to add i_pause and the PAUSE state.       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pong_game_ctrl #(
   parameter int TICK_DIV    = 833333,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_L_X  = 16,
   parameter int PADDLE_R_X  = 616,
   parameter int BALL_SPEED  = 2,
   parameter int SERVE_TICKS = 60,
   parameter int WIN_SCORE   = 7
) (
   input  wire logic   CLOCK_50,
   input  wire logic   rst_n,
   input  wire logic   i_start,
`ifdef PONG_PAUSE_EN
   input  wire logic   i_pause,
`endif
   pong_game_if.master io_game
);

   localparam int                       c_CNT_W     = $clog2(TICK_DIV);
   localparam logic [c_CNT_W-1:0]       c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
   localparam logic [c_CNT_W-1:0]       c_CNT_ONE   = c_CNT_W'(1);
   localparam int                       c_SRV_W     = $clog2(SERVE_TICKS + 2);
   localparam logic [c_SRV_W-1:0]       c_SERVE     = c_SRV_W'(SERVE_TICKS);
   localparam logic [c_SRV_W-1:0]       c_SRV_ONE   = c_SRV_W'(1);
   localparam logic [9:0]               c_CX        = 10'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [9:0]               c_CY        = 10'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [9:0]               c_X_MAX10   = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [9:0]               c_Y_MAX10   = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic [9:0]               c_L_STOP10  = 10'(PADDLE_L_X + PADDLE_W);
   localparam logic [9:0]               c_R_STOP10  = 10'(PADDLE_R_X - BALL_SIZE);
   localparam logic signed [10:0]       c_S         = 11'(BALL_SPEED);
   localparam logic signed [10:0]       c_X_MAX     = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic signed [10:0]       c_Y_MAX     = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic signed [10:0]       c_L_FACE    = 11'(PADDLE_L_X + PADDLE_W);
   localparam logic signed [10:0]       c_R_FACE    = 11'(PADDLE_R_X);
   localparam logic signed [10:0]       c_BS        = 11'(BALL_SIZE);
   localparam logic [11:0]              c_BS12      = 12'(BALL_SIZE);
   localparam logic [11:0]              c_PH12      = 12'(PADDLE_H);
   localparam logic [3:0]               c_WIN       = 4'(WIN_SCORE);
   localparam logic [3:0]               c_SCORE_ONE = 4'd1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4,
      ST_PAUSE = 3'd5
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_tick_cnt;
   logic [c_SRV_W-1:0]  r_serve_cnt;
   logic [9:0]          r_ball_x;
   logic [9:0]          r_ball_y;
   logic [3:0]          r_score_l;
   logic [3:0]          r_score_r;
   logic                r_dx_neg;
   logic                r_dy_neg;
   logic                r_serve_dy_neg;   // dy direction used at the most recent serve
   logic                r_left_scored;    // who took the point now being resolved
   logic                r_start_meta;
   logic                r_start_sync;
   logic                r_start_dly;

   logic                w_tick;
   logic                w_start_pulse;
   logic                w_restart;
   logic                w_winner;
   logic signed [10:0]  w_bx;
   logic signed [10:0]  w_by;
   logic signed [10:0]  w_dx;
   logic signed [10:0]  w_dy;
   logic signed [10:0]  w_nx;
   logic signed [10:0]  w_ny;
   logic [11:0]         w_top;
   logic [11:0]         w_bot;
   logic [11:0]         w_pl_top;
   logic [11:0]         w_pr_top;
   logic                w_ovl_l;
   logic                w_ovl_r;
   logic                w_hit_l;
   logic                w_hit_r;

   // ---------------------------------------------------------------- frame tick
   assign w_tick = (r_tick_cnt == c_TICK_LAST);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         r_tick_cnt <= '0;
      else if (w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
   end

   // ---------------------------------------------------------------- input sync
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_start_meta <= 1'b0;
         r_start_sync <= 1'b0;
         r_start_dly  <= 1'b0;
      end else begin
         r_start_meta <= i_start;
         r_start_sync <= r_start_meta;
         r_start_dly  <= r_start_sync;
      end
   end

   assign w_start_pulse = r_start_sync & ~r_start_dly;

`ifdef PONG_PAUSE_EN
   logic r_pause_meta;
   logic r_pause_sync;
   logic r_pause_dly;
   logic r_resume;     // un-pause requested, applied on the next frame tick
   logic w_pause_pulse;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_pause_meta <= 1'b0;
         r_pause_sync <= 1'b0;
         r_pause_dly  <= 1'b0;
      end else begin
         r_pause_meta <= i_pause;
         r_pause_sync <= r_pause_meta;
         r_pause_dly  <= r_pause_sync;
      end
   end

   assign w_pause_pulse = r_pause_sync & ~r_pause_dly;
   assign w_restart     = w_start_pulse &&
                          (r_state == ST_IDLE || r_state == ST_OVER || r_state == ST_PAUSE);
`else
   assign w_restart     = w_start_pulse && (r_state == ST_IDLE || r_state == ST_OVER);
`endif

   // ---------------------------------------------------------------- motion
   assign w_bx = $signed({1'b0, r_ball_x});
   assign w_by = $signed({1'b0, r_ball_y});
   assign w_dx = r_dx_neg ? -c_S : c_S;
   assign w_dy = r_dy_neg ? -c_S : c_S;
   assign w_nx = w_bx + w_dx;
   assign w_ny = w_by + w_dy;

   // Overlap uses the pre-move y; 12 bits so paddle_y + PADDLE_H cannot wrap.
   assign w_top    = {2'b00, r_ball_y};
   assign w_bot    = w_top + c_BS12;
   assign w_pl_top = {2'b00, io_game.paddleL_y};
   assign w_pr_top = {2'b00, io_game.paddleR_y};
   assign w_ovl_l  = (w_bot > w_pl_top) && (w_top < w_pl_top + c_PH12);
   assign w_ovl_r  = (w_bot > w_pr_top) && (w_top < w_pr_top + c_PH12);

   // The "was in front of the face" terms stop a ball that already slipped
   // past a paddle from being caught from behind.
   assign w_hit_l = r_dx_neg && (w_nx <= c_L_FACE) && (w_bx >= c_L_FACE) && w_ovl_l;
   assign w_hit_r = !r_dx_neg && (w_nx + c_BS >= c_R_FACE) && (w_bx + c_BS <= c_R_FACE) && w_ovl_r;

   assign w_winner = r_left_scored ? (r_score_l >= c_WIN) : (r_score_r >= c_WIN);

   // ---------------------------------------------------------------- game FSM
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_serve_cnt    <= '0;
         r_ball_x       <= c_CX;
         r_ball_y       <= c_CY;
         r_score_l      <= '0;
         r_score_r      <= '0;
         r_dx_neg       <= 1'b0;
         r_dy_neg       <= 1'b0;
         r_serve_dy_neg <= 1'b0;
         r_left_scored  <= 1'b0;
`ifdef PONG_PAUSE_EN
         r_resume       <= 1'b0;
`endif
      end else if (w_restart) begin
         r_state        <= ST_SERVE;
         r_serve_cnt    <= c_SERVE;
         r_ball_x       <= c_CX;
         r_ball_y       <= c_CY;
         r_score_l      <= '0;
         r_score_r      <= '0;
         r_dx_neg       <= 1'b0;
         r_dy_neg       <= 1'b0;
         r_serve_dy_neg <= 1'b0;
`ifdef PONG_PAUSE_EN
         r_resume       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_SERVE: begin
               if (w_tick) begin
                  if (r_serve_cnt <= c_SRV_ONE) begin
                     r_serve_cnt <= '0;
                     r_state     <= ST_PLAY;
                  end else begin
                     r_serve_cnt <= r_serve_cnt - c_SRV_ONE;
                  end
               end
            end

            ST_PLAY: begin
`ifdef PONG_PAUSE_EN
               if (w_pause_pulse) begin
                  r_state  <= ST_PAUSE;
                  r_resume <= 1'b0;
               end else
`endif
               if (w_tick) begin
                  // vertical: walls reflect and clamp
                  if (w_ny[10] || (w_ny == 11'sd0)) begin
                     r_ball_y <= '0;
                     r_dy_neg <= 1'b0;
                  end else if (w_ny >= c_Y_MAX) begin
                     r_ball_y <= c_Y_MAX10;
                     r_dy_neg <= 1'b1;
                  end else begin
                     r_ball_y <= w_ny[9:0];
                  end

                  // horizontal: paddles first, then the scoring edges
                  if (w_hit_l) begin
                     r_ball_x <= c_L_STOP10;
                     r_dx_neg <= 1'b0;
                  end else if (w_hit_r) begin
                     r_ball_x <= c_R_STOP10;
                     r_dx_neg <= 1'b1;
                  end else if (w_nx[10] || (w_nx == 11'sd0)) begin
                     r_ball_x      <= '0;
                     r_left_scored <= 1'b0;
                     r_state       <= ST_POINT;
                     if (r_score_r < c_WIN)
                        r_score_r <= r_score_r + c_SCORE_ONE;
                  end else if (w_nx >= c_X_MAX) begin
                     r_ball_x      <= c_X_MAX10;
                     r_left_scored <= 1'b1;
                     r_state       <= ST_POINT;
                     if (r_score_l < c_WIN)
                        r_score_l <= r_score_l + c_SCORE_ONE;
                  end else begin
                     r_ball_x <= w_nx[9:0];
                  end
               end
            end

            ST_POINT: begin
               if (w_tick) begin
                  if (w_winner) begin
                     r_state <= ST_OVER;
                  end else begin
                     // serve toward whoever lost the point, alternating dy
                     r_state        <= ST_SERVE;
                     r_serve_cnt    <= c_SERVE;
                     r_ball_x       <= c_CX;
                     r_ball_y       <= c_CY;
                     r_dx_neg       <= ~r_left_scored;
                     r_dy_neg       <= ~r_serve_dy_neg;
                     r_serve_dy_neg <= ~r_serve_dy_neg;
                  end
               end
            end

`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
               if (w_tick && r_resume) begin
                  r_state  <= ST_PLAY;
                  r_resume <= 1'b0;
               end else if (w_pause_pulse) begin
                  r_resume <= 1'b1;
               end
            end
`endif

            ST_IDLE, ST_OVER: begin
               r_state <= r_state;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign io_game.ball_x     = r_ball_x;
   assign io_game.ball_y     = r_ball_y;
   assign io_game.score_l    = r_score_l;
   assign io_game.score_r    = r_score_r;
   assign io_game.game_state = r_state;
   assign io_game.frame_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pong_game_ctrl                                              |
// | Purpose : Self-checking bench for pong_game_ctrl. Random start/paddle    |
// |           (and pause, when PONG_PAUSE_EN is defined) stimulus against a  |
// |           per-edge behavioural model of the game rules.                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pong_game_ctrl;
   localparam int TD    = 4;
   localparam int STK   = 2;
   localparam int WIN   = 2;
   localparam int S     = 2;
   localparam int CX    = 316;
   localparam int CY    = 236;
   localparam int XMAX  = 632;
   localparam int YMAX  = 472;
   localparam int LFACE = 24;
   localparam int RFACE = 616;
   localparam int BS    = 8;
   localparam int PH    = 64;

   logic CLOCK_50 = 1'b0;
   logic rst_n;
   logic i_start;
`ifdef PONG_PAUSE_EN
   logic i_pause;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // model of the game, in plain integers
   int m_state, m_x, m_y, m_vx, m_vy, m_sl, m_sr;
   int m_serve_left, m_serve_vy, m_scorer_left, m_edges, m_pend;
   int h_start [3];
   int h_pause [3];

   pong_game_if u_if ();

   pong_game_ctrl #(
      .TICK_DIV(TD), .SERVE_TICKS(STK), .WIN_SCORE(WIN), .BALL_SPEED(S)
   ) u_dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .i_start  (i_start),
`ifdef PONG_PAUSE_EN
      .i_pause  (i_pause),
`endif
      .io_game  (u_if)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_x = CX; m_y = CY; m_vx = S; m_vy = S; m_sl = 0; m_sr = 0;
      m_serve_left = 0; m_serve_vy = S; m_scorer_left = 0; m_edges = 0; m_pend = 0;
      for (int k = 0; k < 3; k++) begin
         h_start[k] = 0;
         h_pause[k] = 0;
      end
   endtask

   task automatic model_play(input int pl, input int pr);
      int nx, ny, ox, oy;
      ox = m_x; oy = m_y;
      nx = m_x + m_vx; ny = m_y + m_vy;
      if (ny <= 0)         begin m_y = 0;    m_vy = S;  end
      else if (ny >= YMAX) begin m_y = YMAX; m_vy = -S; end
      else                 m_y = ny;
      if (m_vx < 0 && nx <= LFACE && ox >= LFACE && oy + BS > pl && oy < pl + PH) begin
         m_x = LFACE; m_vx = S;
      end else if (m_vx > 0 && nx + BS >= RFACE && ox + BS <= RFACE && oy + BS > pr && oy < pr + PH) begin
         m_x = RFACE - BS; m_vx = -S;
      end else if (nx <= 0) begin
         m_x = 0; m_sr++; m_scorer_left = 0; m_state = 3;
      end else if (nx >= XMAX) begin
         m_x = XMAX; m_sl++; m_scorer_left = 1; m_state = 3;
      end else begin
         m_x = nx;
      end
   endtask

   // Advance the model across one rising clock edge.
   task automatic model_edge(input int st, input int ps, input int pl, input int pr);
      bit tick, sp, pp;
      tick = (m_edges % TD) == (TD - 1);
      m_edges++;
      sp = (h_start[1] != 0) && (h_start[0] == 0);
      pp = (h_pause[1] != 0) && (h_pause[0] == 0);
      h_start[0] = h_start[1]; h_start[1] = h_start[2]; h_start[2] = st;
      h_pause[0] = h_pause[1]; h_pause[1] = h_pause[2]; h_pause[2] = ps;
      if (sp && (m_state == 0 || m_state == 4 || m_state == 5)) begin
         m_state = 1; m_x = CX; m_y = CY; m_vx = S; m_vy = S; m_serve_vy = S;
         m_sl = 0; m_sr = 0; m_serve_left = STK; m_pend = 0;
      end else if (pp && m_state == 2) begin
         m_state = 5; m_pend = 0;
      end else begin
         case (m_state)
            1: if (tick) begin
                  m_serve_left--;
                  if (m_serve_left <= 0) m_state = 2;
               end
            2: if (tick) model_play(pl, pr);
            3: if (tick) begin
                  if ((m_scorer_left != 0 ? m_sl : m_sr) >= WIN) m_state = 4;
                  else begin
                     m_x = CX; m_y = CY;
                     m_vx = (m_scorer_left != 0) ? S : -S;
                     m_serve_vy = -m_serve_vy; m_vy = m_serve_vy;
                     m_serve_left = STK; m_state = 1;
                  end
               end
            5: begin
                  if (tick && m_pend != 0) begin m_state = 2; m_pend = 0; end
                  else if (pp) m_pend = 1;
               end
            default: ;
         endcase
      end
   endtask

   function automatic int pick_paddle();
      int p;
      if ($urandom_range(0, 9) < 7) begin
         p = m_y + 7 - int'($urandom_range(0, 70));
         if (p < 0) p = 0;
      end else begin
         p = int'($urandom_range(0, 1023));
      end
      return p;
   endfunction

   task automatic check_outputs();
      chk("ball_x",     u_if.ball_x,     m_x);
      chk("ball_y",     u_if.ball_y,     m_y);
      chk("score_l",    u_if.score_l,    m_sl);
      chk("score_r",    u_if.score_r,    m_sr);
      chk("game_state", u_if.game_state, m_state);
      chk("frame_tick", u_if.frame_tick, ((m_edges % TD) == (TD - 1)) ? 1 : 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ball_x"},  u_if.ball_x,     CX);
      chk({tag, "_ball_y"},  u_if.ball_y,     CY);
      chk({tag, "_score_l"}, u_if.score_l,    0);
      chk({tag, "_score_r"}, u_if.score_r,    0);
      chk({tag, "_state"},   u_if.game_state, 0);
      chk({tag, "_tick"},    u_if.frame_tick, 0);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic run_cycle(input int st, input int ps);
      int pl, pr;
      i_start = st[0];
`ifdef PONG_PAUSE_EN
      i_pause = ps[0];
`endif
      pl = pick_paddle();
      pr = pick_paddle();
      u_if.paddleL_y = pl[9:0];
      u_if.paddleR_y = pr[9:0];
      @(posedge CLOCK_50);
      #1;
      model_edge(st, ps, pl, pr);
      check_outputs();
      @(negedge CLOCK_50);
   endtask

   initial begin
      int st_lvl;
      int ps_lvl;
      rst_n = 1'b0;
      i_start = 1'b0;
`ifdef PONG_PAUSE_EN
      i_pause = 1'b0;
`endif
      u_if.paddleL_y = '0;
      u_if.paddleR_y = '0;
      st_lvl = 0;
      ps_lvl = 0;

      repeat (3) @(negedge CLOCK_50);
      #1 check_reset("reset");
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      model_reset();

      // idle with start low: nothing moves, tick every fourth cycle
      for (int i = 0; i < 12; i++) run_cycle(0, 0);

      // first game start, through serve into play
      st_lvl = 1;
      for (int i = 0; i < 40; i++) run_cycle(st_lvl, 0);

      // random play: start and pause toggle occasionally, paddles mostly track
      for (int i = 0; i < 22000; i++) begin
         if (n_chk - n_pass > 40) break;
         if (i == 11000) begin
            rst_n = 1'b0;
            #1 check_reset("mid_reset");
            @(negedge CLOCK_50);
            rst_n = 1'b1;
            model_reset();
         end
         if ($urandom_range(0, 39) == 0) st_lvl = 1 - st_lvl;
`ifdef PONG_PAUSE_EN
         if ($urandom_range(0, 59) == 0) ps_lvl = 1 - ps_lvl;
`endif
         run_cycle(st_lvl, ps_lvl);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
